// File: rtl/chunked_add_sub_if.sv
// Operand/result bundle of the chunked adder/subtractor: the requester drives
// start/sub/x/y and the adder returns busy/done/s/cout/ovf.
interface chunked_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, x, y, input busy, done, s, cout, ovf);
  modport slave  (input start, sub, x, y, output busy, done, s, cout, ovf);
endinterface

// File: rtl/chunked_add_sub.sv
// Iterative ripple adder/subtractor: CHUNK bits summed per clock, with the
// carry registered between slices, so WIDTH is not limited by one carry path.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for start; s/cout/ovf hold the last completed result
//   ST_RUN  | one slice per edge; the last slice publishes s/cout/ovf
//   ST_DONE | one-cycle done pulse; start here begins the next op at once
module chunked_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              rst,
  chunked_add_sub_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("chunked_add_sub: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   slice_sum;
  logic             c_msb;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    a_sl      = a_q[idx_q*CHUNK +: CHUNK];
    b_sl      = b_q[idx_q*CHUNK +: CHUNK];
    slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the top bit, recovered from the top sum bit of the last slice.
    c_msb     = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ slice_sum[CHUNK-1];

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          a_d     = bus.x;
          b_d     = bus.sub ? ~bus.y : bus.y;
          carry_d = bus.sub;
          idx_d   = '0;
          acc_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d[idx_q*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
        carry_d = slice_sum[CHUNK];
        idx_d   = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) begin
          s_d     = acc_d;
          cout_d  = slice_sum[CHUNK];
          ovf_d   = c_msb ^ slice_sum[CHUNK];
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_chunked_add_sub.sv
// Bench for chunked_add_sub: a 16/4 instance and an 8/8 instance checked
// against an integer-arithmetic reference of add/sub, carry and overflow.
module tb_chunked_add_sub;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  chunked_add_sub_if #(.WIDTH(16)) bus ();
  chunked_add_sub_if #(.WIDTH(8))  bus8 ();

  chunked_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  chunked_add_sub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] last_s;
  logic        last_c;
  logic        last_o;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as unsigned and signed values.
  function automatic void model(input bit sb, input longint xv, input longint yv, input int w,
                                output longint sv, output bit co, output bit ov);
    longint m;
    longint xs;
    longint ys;
    longint r;
    m = longint'(1) << w;
    if (sb) begin
      sv = (xv - yv + m) % m;
      co = (xv >= yv);
    end else begin
      sv = (xv + yv) % m;
      co = ((xv + yv) >= m);
    end
    xs = (xv >= m / 2) ? xv - m : xv;
    ys = (yv >= m / 2) ? yv - m : yv;
    r  = sb ? xs - ys : xs + ys;
    ov = (r >= m / 2) || (r < -(m / 2));
  endfunction

  task automatic run_op(input bit sb, input logic [15:0] xv, input logic [15:0] yv, input bit scramble);
    longint es;
    bit     ec;
    bit     eo;
    model(sb, longint'(xv), longint'(yv), 16, es, ec, eo);
    bus.start = 1'b1;
    bus.sub   = sb;
    bus.x     = xv;
    bus.y     = yv;
    tick();
    chk("busy_e0", bus.busy, 1);
    chk("done_e0", bus.done, 0);
    for (int k = 1; k <= 3; k++) begin
      if (scramble) begin
        bus.start = 1'($urandom);
        bus.sub   = 1'($urandom);
        bus.x     = 16'($urandom);
        bus.y     = 16'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      tick();
      chk("busy_run", bus.busy, 1);
      chk("done_run", bus.done, 0);
      chk("s_hold_run", bus.s, last_s);
    end
    tick();
    bus.start = 1'b0;
    chk("done_pulse", bus.done, 1);
    chk("busy_done", bus.busy, 0);
    chk("s_result", bus.s, 32'(es));
    chk("cout_result", bus.cout, ec);
    chk("ovf_result", bus.ovf, eo);
    tick();
    chk("done_one_cycle", bus.done, 0);
    chk("busy_idle", bus.busy, 0);
    last_s = 16'(es);
    last_c = ec;
    last_o = eo;
  endtask

  initial begin
    longint      es;
    bit          ec;
    bit          eo;
    logic [15:0] ax, ay, bx, by;
    bit          bsub;
    logic [7:0]  x8, y8;
    bit          s8;

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    bus8.start = 1'b0;
    bus8.sub   = 1'b0;
    bus8.x     = '0;
    bus8.y     = '0;
    last_s = '0;
    last_c = 1'b0;
    last_o = 1'b0;

    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_s", bus.s, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst8_s", bus8.s, 0);
    chk("rst8_done", bus8.done, 0);
    rst = 1'b0;
    tick();

    run_op(1'b0, 16'h1234, 16'h0FFF, 1'b0);
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    run_op(1'b1, 16'h0005, 16'h0007, 1'b0);
    run_op(1'b1, 16'h8000, 16'h0001, 1'b0);
    run_op(1'b1, 16'h0000, 16'h0000, 1'b0);

    for (int n = 0; n < 24; n++) begin
      run_op(1'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    end

    // Back-to-back: start held high, operands scrambled during the first op.
    ax = 16'($urandom);
    ay = 16'($urandom);
    bx = 16'($urandom);
    by = 16'($urandom);
    bsub = 1'b1;
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.x     = ax;
    bus.y     = ay;
    tick();
    for (int k = 1; k <= 3; k++) begin
      bus.x   = 16'($urandom);
      bus.y   = 16'($urandom);
      bus.sub = 1'($urandom);
      tick();
      chk("b2b_busy_a", bus.busy, 1);
    end
    bus.x   = bx;
    bus.y   = by;
    bus.sub = bsub;
    tick();
    model(1'b0, longint'(ax), longint'(ay), 16, es, ec, eo);
    chk("b2b_done_a", bus.done, 1);
    chk("b2b_s_a", bus.s, 32'(es));
    chk("b2b_cout_a", bus.cout, ec);
    last_s = 16'(es);
    tick();
    bus.start = 1'b0;
    chk("b2b_busy_b", bus.busy, 1);
    chk("b2b_done_drop", bus.done, 0);
    for (int k = 6; k <= 8; k++) begin
      tick();
      chk("b2b_s_hold", bus.s, last_s);
      chk("b2b_nodone", bus.done, 0);
    end
    tick();
    model(bsub, longint'(bx), longint'(by), 16, es, ec, eo);
    chk("b2b_done_b", bus.done, 1);
    chk("b2b_s_b", bus.s, 32'(es));
    chk("b2b_cout_b", bus.cout, ec);
    chk("b2b_ovf_b", bus.ovf, eo);
    tick();
    chk("b2b_idle", bus.done, 0);
    last_s = 16'(es);

    // Reset in the middle of an op: abort, clear outputs, no done pulse.
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.x     = 16'h1234;
    bus.y     = 16'h0FFF;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_s", bus.s, 0);
    chk("mid_rst_cout", bus.cout, 0);
    chk("mid_rst_ovf", bus.ovf, 0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mid_rst_nodone", bus.done, 0);
      chk("mid_rst_s_hold", bus.s, 0);
    end
    last_s = '0;
    run_op(1'b0, 16'h1234, 16'h0FFF, 1'b0);

    // Single-slice instance: done one edge after start.
    bus8.start = 1'b1;
    bus8.sub   = 1'b0;
    bus8.x     = 8'h80;
    bus8.y     = 8'h80;
    tick();
    bus8.start = 1'b0;
    chk("w8_busy", bus8.busy, 1);
    chk("w8_done_e0", bus8.done, 0);
    tick();
    chk("w8_done", bus8.done, 1);
    chk("w8_s", bus8.s, 8'h00);
    chk("w8_cout", bus8.cout, 1);
    chk("w8_ovf", bus8.ovf, 1);
    tick();
    chk("w8_done_drop", bus8.done, 0);
    for (int n = 0; n < 8; n++) begin
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      s8 = 1'($urandom);
      bus8.start = 1'b1;
      bus8.sub   = s8;
      bus8.x     = x8;
      bus8.y     = y8;
      tick();
      bus8.start = 1'b0;
      bus8.x     = 8'($urandom);
      tick();
      model(s8, longint'(x8), longint'(y8), 8, es, ec, eo);
      chk("w8r_done", bus8.done, 1);
      chk("w8r_s", bus8.s, 32'(es));
      chk("w8r_cout", bus8.cout, ec);
      chk("w8r_ovf", bus8.ovf, eo);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
